// File: rtl/uart_rx.sv
// UART receiver: 16x oversampling, LSB first, configurable data/stop length.
// Define UART_RX_PARITY_EN to expect and check one even-parity bit after the data.
module uart_rx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx,
    input  logic       s_tick,
    output logic [7:0] dout,
    output logic       rx_done_tick,
    output logic       frame_err,
    output logic       parity_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Tick counter is five bits so stop lengths up to 32 ticks fit.
    localparam logic [4:0] S_MID       = 5'd7;
    localparam logic [4:0] S_LAST      = 5'd15;
    localparam logic [4:0] S_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST      = 3'(DBIT - 1);

    logic [1:0]      r_rst_sync;
    logic            w_rst_n;
    logic [1:0]      r_rx_sync;
    logic            w_rx;
    state_t          r_state;
    logic [4:0]      r_s;
    logic [2:0]      r_n;
    logic [DBIT-1:0] r_b;
    logic [7:0]      r_dout;
    logic            r_done;
    logic            r_ferr;

    // Reset bridge: assertion passes straight through, release waits two clk edges.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rst_sync <= 2'b00;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    // Two-flop synchronizer for the asynchronous serial line.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_rx_sync <= 2'b11;
        end else begin
            r_rx_sync <= {r_rx_sync[0], rx};
        end
    end

    assign w_rx = r_rx_sync[1];

`ifdef UART_RX_PARITY_EN
    logic r_perr;
    logic r_parity_err;

    function automatic logic f_even_par(input logic [DBIT-1:0] d);
        return ^d;
    endfunction
`endif

    // Frame FSM with counters, shift register and registered result outputs.
    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state <= ST_IDLE;
            r_s     <= 5'd0;
            r_n     <= 3'd0;
            r_b     <= '0;
            r_dout  <= 8'd0;
            r_done  <= 1'b0;
            r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_perr       <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx) begin
                        r_state <= ST_START;
                        r_s     <= 5'd0;
                    end
                end
                ST_START: begin
                    if (s_tick) begin
                        if (r_s == S_MID) begin
                            if (!w_rx) begin
                                r_state <= ST_DATA;
                                r_s     <= 5'd0;
                                r_n     <= 3'd0;
                            end else begin
                                r_state <= ST_IDLE;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                ST_DATA: begin
                    if (s_tick) begin
                        if (r_s == S_LAST) begin
                            r_s <= 5'd0;
                            r_b <= {w_rx, r_b[DBIT-1:1]};
                            if (r_n == N_LAST) begin
`ifdef UART_RX_PARITY_EN
                                r_state <= ST_PARITY;
`else
                                r_state <= ST_STOP;
`endif
                            end else begin
                                r_n <= r_n + 3'd1;
                            end
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (s_tick) begin
                        if (r_s == S_LAST) begin
                            r_perr  <= w_rx ^ f_even_par(r_b);
                            r_s     <= 5'd0;
                            r_state <= ST_STOP;
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
`endif
                ST_STOP: begin
                    if (s_tick) begin
                        if (r_s == S_STOP_LAST) begin
                            r_state <= ST_IDLE;
                            r_dout  <= 8'(r_b);
                            r_ferr  <= ~w_rx;
                            r_done  <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            r_parity_err <= r_perr;
`endif
                        end else begin
                            r_s <= r_s + 5'd1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign dout         = r_dout;
    assign rx_done_tick = r_done;
    assign frame_err    = r_ferr;
`ifdef UART_RX_PARITY_EN
    assign parity_err   = r_parity_err;
`else
    assign parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: one 8-bit/1-stop instance and one 7-bit/2-stop instance.
module tb_uart_rx;

    logic       clk;
    logic       reset_n;
    logic       s_tick;
    logic       rx8;
    logic       rx7;
    logic [7:0] dout8;
    logic [7:0] dout7;
    logic       done8;
    logic       done7;
    logic       fe8;
    logic       fe7;
    logic       pe8;
    logic       pe7;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int n8          = 0;
    int n7          = 0;
    int exp8        = 0;
    logic [7:0] cap7 [0:3];
    logic       bit7;

    uart_rx #(.DBIT(8), .SB_TICK(16)) dut8 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx8),
        .s_tick       (s_tick),
        .dout         (dout8),
        .rx_done_tick (done8),
        .frame_err    (fe8),
        .parity_err   (pe8)
    );

    uart_rx #(.DBIT(7), .SB_TICK(32)) dut7 (
        .clk          (clk),
        .reset_n      (reset_n),
        .rx           (rx7),
        .s_tick       (s_tick),
        .dout         (dout7),
        .rx_done_tick (done7),
        .frame_err    (fe7),
        .parity_err   (pe7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: counts done cycles and records the word shown with each pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) n8++;
        if (done7 === 1'b1) begin
            if (n7 < 4) cap7[n7] = dout7;
            n7++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clk per iteration; s_tick pulses every fourth clk (16 ticks = 64 clks per bit).
    task automatic step(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
            cyc++;
            s_tick = (cyc % 4 == 0);
        end
    endtask

    task automatic hold(input bit sel, input bit v, input int k);
        if (sel) rx7 = v;
        else     rx8 = v;
        step(k);
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data, input int nd,
                              input bit stop_v, input int stop_clks, input bit bad_par);
        bit par;
        par = bad_par;
        hold(sel, 1'b0, 64);
        for (int i = 0; i < nd; i++) begin
            par ^= data[i];
            hold(sel, data[i], 64);
        end
`ifdef UART_RX_PARITY_EN
        hold(sel, par, 64);
`endif
        hold(sel, stop_v, stop_clks);
        hold(sel, 1'b1, 0);
    endtask

    initial begin
        rx8     = 1'b1;
        rx7     = 1'b1;
        s_tick  = 1'b0;
        reset_n = 1'b0;
        step(5);
        check("reset_dout8", dout8, 8'h00);
        check("reset_done8", done8, 1'b0);
        check("reset_fe8",   fe8,   1'b0);
        check("reset_pe8",   pe8,   1'b0);
        check("reset_dout7", dout7, 8'h00);
        reset_n = 1'b1;
        step(10);

        send_frame(1'b0, 8'hA5, 8, 1'b1, 64, 1'b0);
        step(40);
        exp8++;
        check("a5_pulses", n8,    exp8);
        check("a5_dout",   dout8, 8'hA5);
        check("a5_ferr",   fe8,   1'b0);
        check("a5_perr",   pe8,   1'b0);

        hold(1'b0, 1'b0, 16);
        hold(1'b0, 1'b1, 200);
        check("glitch_pulses", n8,    exp8);
        check("glitch_dout",   dout8, 8'hA5);

        send_frame(1'b0, 8'h3C, 8, 1'b0, 40, 1'b0);
        hold(1'b0, 1'b1, 200);
        exp8++;
        check("fe_pulses", n8,    exp8);
        check("fe_dout",   dout8, 8'h3C);
        check("fe_ferr",   fe8,   1'b1);
        check("fe_perr",   pe8,   1'b0);

`ifdef UART_RX_PARITY_EN
        send_frame(1'b0, 8'h07, 8, 1'b1, 64, 1'b1);
        step(40);
        exp8++;
        check("par0_pulses", n8,    exp8);
        check("par0_dout",   dout8, 8'h07);
        check("par0_perr",   pe8,   1'b1);
        send_frame(1'b0, 8'h07, 8, 1'b1, 64, 1'b0);
        step(40);
        exp8++;
        check("par1_pulses", n8,  exp8);
        check("par1_perr",   pe8, 1'b0);
        check("par1_ferr",   fe8, 1'b0);
`endif

        hold(1'b0, 1'b0, 64);
        hold(1'b0, 1'b1, 64 * 3 + 32);
        reset_n = 1'b0;
        #1;
        check("rst_async_dout", dout8, 8'h00);
        check("rst_async_ferr", fe8,   1'b0);
        step(3);
        reset_n = 1'b1;
        hold(1'b0, 1'b1, 900);
        check("rst_no_pulse", n8,    exp8);
        check("rst_dout",     dout8, 8'h00);

        send_frame(1'b0, 8'h12, 8, 1'b1, 64, 1'b0);
        step(40);
        exp8++;
        check("x12_pulses", n8,    exp8);
        check("x12_dout",   dout8, 8'h12);
        check("x12_ferr",   fe8,   1'b0);

        send_frame(1'b1, 8'h55, 7, 1'b1, 128, 1'b0);
        send_frame(1'b1, 8'h2A, 7, 1'b1, 128, 1'b0);
        step(60);
        bit7 = dout7[7];
        check("b2b_pulses", n7,      2);
        check("b2b_first",  cap7[0], 8'h55);
        check("b2b_second", cap7[1], 8'h2A);
        check("b2b_dout",   dout7,   8'h2A);
        check("b2b_msb",    bit7,    1'b0);
        check("b2b_ferr",   fe7,     1'b0);
        check("b2b_perr",   pe7,     1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
